sap_core: RTL and testbench
===========================

SAP_CORE -- requirements
Module: sap_core

Interface
REQ-001 Parameter DW, default 8, data/instruction word width; legal when DW >= 4+AW.
REQ-002 Parameter AW, default 4, address width; memory depth is 2^AW words.
REQ-003 Parameter DIV, default 1, clocks per execution step; legal when DIV >= 1.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 run  input  1  start request, sampled in IDLE or HALT.
REQ-007 prog_we  input  1  program-memory write strobe.
REQ-008 prog_addr  input  AW  program-memory write address.
REQ-009 prog_data  input  DW  program-memory write data.
REQ-010 out_data  output  DW  last value emitted by OUT.
REQ-011 out_valid  output  1  one-clk pulse when out_data updates.
REQ-012 halted  output  1  high while in HALT.
REQ-013 pc  output  AW  program counter.
REQ-014 acc  output  DW  accumulator.
REQ-015 flag_z, flag_c  output  1 each  zero and carry/borrow flags.

Function
REQ-016 Instruction word: opcode = bits [DW-1:DW-4]; operand = bits [AW-1:0]; other bits ignored.
REQ-017 Opcodes: 0 LDA, 1 ADD, 2 SUB, 3 STA, 4 JMP, 5 JZ, 6 JC, 7 LDI, E OUT, F HLT; 8-D execute as NOP.
REQ-018 Divider counts 0..DIV-1 free-running; step asserts in the clk cycle where count = DIV-1; with DIV=1, step asserts every cycle.
REQ-019 FSM states: IDLE, FETCH, DECODE, EXEC, HALT; FETCH, DECODE and EXEC each advance only on step.
REQ-020 IDLE/HALT with run=1 -> FETCH on the next clk edge, independent of step; from HALT, pc is also cleared to 0. acc, flags and memory are retained.
REQ-021 FETCH: IR <= mem[pc]; pc <= pc+1 modulo 2^AW (wrap from 2^AW-1 to 0); -> DECODE.
REQ-022 DECODE: B <= mem[operand]; -> EXEC.
REQ-023 EXEC: LDA acc<=B; ADD {C,acc}<=acc+B; SUB acc<=acc-B mod 2^DW, C<=(acc<B); STA mem[operand]<=acc; JMP pc<=operand; JZ/JC pc<=operand only if Z/C is 1; LDI acc<=zero-extended operand; OUT out_data<=acc; HLT -> HALT; all other opcodes -> FETCH.
REQ-024 Z <= (new acc == 0) after LDA, ADD, SUB and LDI; C changes only on ADD and SUB; all other instructions hold both flags.
REQ-025 out_valid is high for exactly one clk cycle, the cycle after OUT executes, regardless of DIV.
REQ-026 Memory reads are combinational from the register array; a write is visible to the next read.
REQ-027 prog_we is honoured only in IDLE or HALT and is silently ignored elsewhere; it has no effect on state.
REQ-028 If prog_we and run assert in the same cycle, the write completes and the FSM still starts.
REQ-029 Instruction latency is 3 steps (3*DIV clk cycles), plus 1 clk cycle for the IDLE/HALT -> FETCH start.

Reset
REQ-030 rst has priority over all inputs; mid-instruction it aborts the instruction without any memory write.
REQ-031 On reset: state IDLE; pc, acc, B, IR, flag_z, flag_c, out_data, out_valid, halted and the divider count are all 0.
REQ-032 Memory contents are not reset.

Verification
REQ-033 DIV=1; program {LDA 6, ADD 7, OUT, HLT}, mem[6]=5, mem[7]=3; pulse run -> out_data=8 with a single out_valid pulse, then halted=1 and pc=4.
REQ-034 ADD overflow, DW=8: 200+100 -> acc=44, C=1, Z=0; then SUB 44-44 -> acc=0, Z=1, C=0.
REQ-035 Conditional loop {LDI 3, SUB one, JZ end, JMP 1}, one=1 -> exits after acc reaches 0; JC is not taken while C=0.
REQ-036 DIV=4: instruction boundaries are 12 clk cycles apart; prog_we while running leaves memory unchanged; STA 15 then LDA 15 round-trips acc.
REQ-037 Program with no HLT reaching address 15 -> pc wraps to 0; rst asserted during DECODE -> all outputs 0 and state IDLE on the next cycle.

Source files
------------

// File: rtl/sap_core.sv
// sap_core: SAP-style accumulator CPU with an on-chip program/data memory.
// Each instruction takes three execution steps (FETCH, DECODE, EXEC); a
// free-running divider paces the steps at one step every DIV clocks.
module sap_core #(
  parameter int DW  = 8,
  parameter int AW  = 4,
  parameter int DIV = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          halted,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] acc,
  output logic          flag_z,
  output logic          flag_c
);

  localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH = 1 << AW;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JZ  = 4'h5;
  localparam logic [3:0] OP_JC  = 4'h6;
  localparam logic [3:0] OP_LDI = 4'h7;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] ir_q, ir_d;
  logic          z_q, z_d;
  logic          c_q, c_d;
  logic [DW-1:0] out_q, out_d;
  logic          ov_q, ov_d;

  logic [DW-1:0] mem_q [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  logic          step;
  logic [3:0]    opcode;
  logic [AW-1:0] operand;
  logic [DW:0]   sum;
  logic [DW-1:0] diff;
  logic [DW-1:0] imm;

  assign step    = (cnt_q == CW'(DIV - 1));
  assign opcode  = ir_q[DW-1 -: 4];
  assign operand = ir_q[AW-1:0];
  assign sum     = {1'b0, acc_q} + {1'b0, b_q};
  assign diff    = acc_q - b_q;
  assign imm     = {{(DW-AW){1'b0}}, operand};

  // Step divider: free-running 0..DIV-1, step fires on the last count.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst)       cnt_q <= '0;
    else if (step) cnt_q <= '0;
    else           cnt_q <= cnt_q + CW'(1);
  end

  // Next-state and datapath decisions for the fetch/decode/execute sequence.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statements can leave one unassigned and infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    acc_d     = acc_q;
    b_d       = b_q;
    ir_d      = ir_q;
    z_d       = z_q;
    c_d       = c_q;
    out_d     = out_q;
    ov_d      = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = prog_addr;
    mem_wdata = prog_data;

    case (state_q)
      S_IDLE: begin
        mem_we = prog_we;
        if (run) state_d = S_FETCH;
      end
      S_HALT: begin
        mem_we = prog_we;
        if (run) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        if (step) begin
          ir_d    = mem_q[pc_q];
          pc_d    = pc_q + AW'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (step) begin
          b_d     = mem_q[operand];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (step) begin
          state_d = S_FETCH;
          case (opcode)
            OP_LDA: begin
              acc_d = b_q;
              z_d   = (b_q == '0);
            end
            OP_ADD: begin
              {c_d, acc_d} = sum;
              z_d          = (sum[DW-1:0] == '0);
            end
            OP_SUB: begin
              acc_d = diff;
              c_d   = (acc_q < b_q);
              z_d   = (diff == '0);
            end
            OP_STA: begin
              mem_we    = 1'b1;
              mem_waddr = operand;
              mem_wdata = acc_q;
            end
            OP_JMP: pc_d = operand;
            OP_JZ:  if (z_q) pc_d = operand;
            OP_JC:  if (c_q) pc_d = operand;
            OP_LDI: begin
              acc_d = imm;
              z_d   = (imm == '0);
            end
            OP_OUT: begin
              out_d = acc_q;
              ov_d  = 1'b1;
            end
            OP_HLT: state_d = S_HALT;
            default: ;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Architectural registers; reset clears everything except memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      ir_q    <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      out_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
      c_q     <= c_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
    end
  end

  // Program/data memory write port; reset blocks a write from an aborted STA.
  always_ff @(posedge clk) begin
    // NOTE: the memory array has no reset so it maps onto plain storage;
    // contents survive rst and only the write enable is gated by it.
    if (mem_we && !rst) mem_q[mem_waddr] <= mem_wdata;
  end

  assign pc        = pc_q;
  assign acc       = acc_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign out_data  = out_q;
  assign out_valid = ov_q;
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_sap_core.sv
// tb_sap_core: directed and random programs on a DIV=1 core checked against
// an instruction-level model, plus timing/write-protect checks on a DIV=4 core.
module tb_sap_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // DIV=1 instance
  logic       rst1, run1, we1;
  logic [3:0] addr1;
  logic [7:0] data1;
  logic [7:0] out_data1, acc1;
  logic       out_valid1, halted1, z1, c1;
  logic [3:0] pc1;

  // DIV=4 instance
  logic       rst4, run4, we4;
  logic [3:0] addr4;
  logic [7:0] data4;
  logic [7:0] out_data4, acc4;
  logic       out_valid4, halted4, z4, c4;
  logic [3:0] pc4;

  sap_core #(.DW(8), .AW(4), .DIV(1)) u_dut1 (
    .clk(clk), .rst(rst1), .run(run1), .prog_we(we1), .prog_addr(addr1),
    .prog_data(data1), .out_data(out_data1), .out_valid(out_valid1),
    .halted(halted1), .pc(pc1), .acc(acc1), .flag_z(z1), .flag_c(c1)
  );

  sap_core #(.DW(8), .AW(4), .DIV(4)) u_dut4 (
    .clk(clk), .rst(rst4), .run(run4), .prog_we(we4), .prog_addr(addr4),
    .prog_data(data4), .out_data(out_data4), .out_valid(out_valid4),
    .halted(halted4), .pc(pc4), .acc(acc4), .flag_z(z4), .flag_c(c4)
  );

  // Instruction-level reference model
  logic [7:0] m_mem [16];
  logic [7:0] prog  [16];
  int         m_pc, m_acc, m_out;
  bit         m_z, m_c, m_halt;
  int         ov_seen;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset;
    m_pc = 0; m_acc = 0; m_out = 0; m_z = 0; m_c = 0; m_halt = 0;
  endtask

  task automatic model_step(output bit is_out);
    int ir, op, opd, b, s;
    ir   = int'(m_mem[m_pc]);
    m_pc = (m_pc + 1) % 16;
    op   = ir / 16;
    opd  = ir % 16;
    b    = int'(m_mem[opd]);
    is_out = 0;
    case (op)
      0:  begin m_acc = b; m_z = (m_acc == 0); end
      1:  begin s = m_acc + b; m_c = (s > 255); m_acc = s % 256; m_z = (m_acc == 0); end
      2:  begin m_c = (m_acc < b); m_acc = (m_acc - b + 256) % 256; m_z = (m_acc == 0); end
      3:  m_mem[opd] = 8'(m_acc);
      4:  m_pc = opd;
      5:  if (m_z) m_pc = opd;
      6:  if (m_c) m_pc = opd;
      7:  begin m_acc = opd; m_z = (m_acc == 0); end
      14: begin m_out = m_acc; is_out = 1; end
      15: m_halt = 1;
      default: ;
    endcase
  endtask

  task automatic reset1;
    rst1 = 1'b1; run1 = 1'b0; we1 = 1'b0;
    tick; tick;
    rst1 = 1'b0;
    model_reset();
  endtask

  task automatic write1(input logic [3:0] a, input logic [7:0] d);
    we1 = 1'b1; addr1 = a; data1 = d;
    m_mem[a] = d;
    tick;
    we1 = 1'b0;
  endtask

  task automatic load1;
    for (int i = 0; i < 16; i++) write1(4'(i), prog[i]);
  endtask

  task automatic start1(input bit do_we, input logic [3:0] a, input logic [7:0] d);
    run1 = 1'b1; we1 = do_we; addr1 = a; data1 = d;
    if (do_we) m_mem[a] = d;
    if (m_halt) m_pc = 0;
    m_halt = 0;
    tick;
    run1 = 1'b0; we1 = 1'b0;
  endtask

  // Execute up to n instructions, comparing all outputs at each boundary.
  task automatic run_checked1(input string tag, input int n);
    bit is_out;
    for (int i = 0; i < n && !m_halt; i++) begin
      repeat (3) begin
        tick;
        if (out_valid1) ov_seen++;
      end
      model_step(is_out);
      check($sformatf("%s.i%0d.pc", tag, i), pc1, m_pc);
      check($sformatf("%s.i%0d.acc", tag, i), acc1, m_acc);
      check($sformatf("%s.i%0d.z", tag, i), z1, m_z);
      check($sformatf("%s.i%0d.c", tag, i), c1, m_c);
      check($sformatf("%s.i%0d.out", tag, i), out_data1, m_out);
      check($sformatf("%s.i%0d.ov", tag, i), out_valid1, is_out);
      check($sformatf("%s.i%0d.halt", tag, i), halted1, m_halt);
    end
  endtask

  task automatic check_zero1(input string tag);
    check({tag, ".pc"}, pc1, 0);
    check({tag, ".acc"}, acc1, 0);
    check({tag, ".z"}, z1, 0);
    check({tag, ".c"}, c1, 0);
    check({tag, ".out"}, out_data1, 0);
    check({tag, ".ov"}, out_valid1, 0);
    check({tag, ".halt"}, halted1, 0);
  endtask

  task automatic write4(input logic [3:0] a, input logic [7:0] d);
    we4 = 1'b1; addr4 = a; data4 = d;
    tick;
    we4 = 1'b0;
  endtask

  initial begin
    int tchg [8];
    int nchg, ov4, last_pc;
    bit done;

    rst1 = 1'b1; run1 = 1'b0; we1 = 1'b0; addr1 = '0; data1 = '0;
    rst4 = 1'b1; run4 = 1'b0; we4 = 1'b0; addr4 = '0; data4 = '0;

    // Reset state
    reset1();
    check_zero1("rst");

    // LDA 6, ADD 7, OUT, HLT; mem[7] written in the same cycle as run
    prog = '{default: 8'h80};
    prog[0] = 8'h06; prog[1] = 8'h17; prog[2] = 8'hE0; prog[3] = 8'hF0;
    prog[6] = 8'h05; prog[7] = 8'h00;
    load1();
    ov_seen = 0;
    start1(1'b1, 4'd7, 8'h03);
    run_checked1("t033", 10);
    check("t033.out", out_data1, 8);
    check("t033.pulses", ov_seen, 1);
    check("t033.halted", halted1, 1);
    check("t033.pc", pc1, 4);

    // ADD overflow then SUB to zero; loaded while halted, restart clears pc
    prog = '{default: 8'h80};
    prog[0] = 8'h08; prog[1] = 8'h19; prog[2] = 8'h2A; prog[3] = 8'hF0;
    prog[8] = 8'd200; prog[9] = 8'd100; prog[10] = 8'd44;
    load1();
    start1(1'b0, 4'd0, 8'h00);
    check("t034.pc_clear", pc1, 0);
    check("t034.acc_kept", acc1, 8);
    run_checked1("t034a", 2);
    check("t034.add_acc", acc1, 44);
    check("t034.add_c", c1, 1);
    check("t034.add_z", z1, 0);
    run_checked1("t034b", 10);
    check("t034.sub_acc", acc1, 0);
    check("t034.sub_z", z1, 1);
    check("t034.sub_c", c1, 0);

    // Countdown loop with a JC that must never be taken
    prog = '{default: 8'h80};
    prog[0] = 8'h73; prog[1] = 8'h27; prog[2] = 8'h66; prog[3] = 8'h55;
    prog[4] = 8'h41; prog[5] = 8'hF0; prog[6] = 8'hF0; prog[7] = 8'h01;
    load1();
    start1(1'b0, 4'd0, 8'h00);
    run_checked1("t035", 20);
    check("t035.pc", pc1, 6);
    check("t035.acc", acc1, 0);
    check("t035.z", z1, 1);
    check("t035.halted", halted1, 1);

    // No HLT: pc wraps, then reset during DECODE of an STA
    reset1();
    prog = '{default: 8'h80};
    prog[0] = 8'h3E; prog[1] = 8'h75; prog[2] = 8'hE0;
    load1();
    start1(1'b0, 4'd0, 8'h00);
    run_checked1("t037", 16);
    check("t037.wrap", pc1, 0);
    tick;
    rst1 = 1'b1;
    tick;
    rst1 = 1'b0;
    model_reset();
    check_zero1("t037.rst");
    write1(4'd0, 8'h0E); write1(4'd1, 8'hE0); write1(4'd2, 8'hF0);
    start1(1'b0, 4'd0, 8'h00);
    run_checked1("t037v", 5);
    check("t037.no_sta", out_data1, 0);
    check("t037v.halted", halted1, 1);

    // Random programs against the model
    for (int t = 0; t < 6; t++) begin
      reset1();
      for (int i = 0; i < 16; i++) prog[i] = 8'($urandom_range(0, 255));
      load1();
      start1(1'b0, 4'd0, 8'h00);
      run_checked1($sformatf("rnd%0d", t), 24);
    end

    // DIV=4: step spacing, writes ignored while running, STA/LDA round trip
    rst4 = 1'b1; tick; tick; rst4 = 1'b0;
    check("d4.rst.pc", pc4, 0);
    check("d4.rst.halt", halted4, 0);
    for (int i = 0; i < 16; i++) write4(4'(i), 8'h00);
    write4(4'd0, 8'h79); write4(4'd1, 8'h3F); write4(4'd2, 8'h70);
    write4(4'd3, 8'h0F); write4(4'd4, 8'hE0); write4(4'd5, 8'hF0);
    run4 = 1'b1; tick; run4 = 1'b0;
    nchg = 0; ov4 = 0; last_pc = int'(pc4);
    for (int cyc = 1; cyc <= 300 && !halted4; cyc++) begin
      we4 = (cyc >= 5 && cyc <= 8); addr4 = 4'd14; data4 = 8'hAB;
      tick;
      if (out_valid4) ov4++;
      if (int'(pc4) != last_pc) begin
        if (nchg < 8) tchg[nchg] = cyc;
        nchg++;
        last_pc = int'(pc4);
      end
    end
    we4 = 1'b0;
    check("d4.halted", halted4, 1);
    check("d4.fetches", nchg, 6);
    for (int i = 0; i < 5; i++)
      check($sformatf("d4.spacing%0d", i), tchg[i+1] - tchg[i], 12);
    check("d4.acc", acc4, 9);
    check("d4.out", out_data4, 9);
    check("d4.pulses", ov4, 1);
    check("d4.pc", pc4, 6);
    write4(4'd0, 8'h0E); write4(4'd1, 8'hE0); write4(4'd2, 8'hF0);
    run4 = 1'b1; tick; run4 = 1'b0;
    done = 0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      tick;
      done = halted4;
    end
    check("d4.rerun_halted", halted4, 1);
    check("d4.we_ignored", out_data4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
